// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared types and constants for the Dino Run timing and
//                sequencing controller: game state encoding, bus widths and
//                the default tick period exponents.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Game state encoding as seen on the `state` output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int c_LEVEL_W = 2;   // width of the difficulty level
    localparam int c_PRESC_W = 31;  // free-running prescaler width
    localparam int c_EXP_W   = 5;   // tick exponent width (exponents 0..30)

    // Default period exponents (period = 2**LOG2 system clocks).
    localparam int c_DEF_PIX_LOG2    = 1;
    localparam int c_DEF_SEG_LOG2    = 17;
    localparam int c_DEF_DINO_LOG2   = 21;
    localparam int c_DEF_CACTUS_LOG2 = 21;
    localparam int c_DEF_BLINK_LOG2  = 25;
    localparam int c_DEF_OBST_LOG2   = 30;
    localparam int c_DEF_LVL_STEP    = 512;
    localparam int c_DEF_MAX_LEVEL   = 3;

endpackage : game_pkg
`default_nettype wire

// File: rtl/game_tick_sched_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Registered one-cycle clock-enable pulse derived from the
//                shared prescaler. The pulse fires on the cycle after the low
//                i_exp bits of the prescaler are all ones, so a pulse of
//                exponent k repeats every 2**k cycles and survives the
//                prescaler wrap for any k <= 30.
//  Ports       : clk     - system clock
//                clr_n   - synchronous active-low reset
//                i_q     - prescaler value
//                i_exp   - runtime period exponent
//                i_gate  - qualifies the pulse (tie high for free-running)
//                o_tick  - registered one-cycle enable pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
    import game_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [c_PRESC_W-1:0] i_q,
    input  logic [c_EXP_W-1:0]   i_exp,
    input  logic                 i_gate,
    output logic                 o_tick
);

    logic [c_PRESC_W-1:0] w_mask;
    logic                 w_raw;
    logic                 r_tick;

    // Mask with the low i_exp bits set; exponent 0 gives an empty mask,
    // which degenerates to a tick every cycle.
    assign w_mask = ~({c_PRESC_W{1'b1}} << i_exp);
    assign w_raw  = ((i_q & w_mask) == w_mask);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_raw & i_gate;
        end
    end

    assign o_tick = r_tick;

endmodule : tick_gen
`default_nettype wire

// File: rtl/game_tick_sched.sv
`default_nettype none
// ============================================================================
//  Module      : game_tick_sched
//  Description : Central timing and sequencing controller for Dino Run.
//                Generates single-cycle clock-enable ticks from one shared
//                prescaler, runs the idle/run/pause/over game state machine
//                and owns the difficulty level that speeds up the cactus.
//  Ports       : clk          - 50 MHz system clock
//                clr_n        - synchronous active-low reset
//                start        - pulse: begin / restart a game
//                pause_req    - pulse: toggle RUN and PAUSE
//                collide      - pulse: dino/cactus hit
//                pix_en       - pixel enable (free-running)
//                seg_en       - 7-segment scan enable (free-running)
//                blink_tick   - blink enable (free-running)
//                dino_tick    - dino tick (RUN only)
//                cactus_tick  - cactus scroll tick (RUN only, level scaled)
//                obst_tick    - obstacle spawn tick (RUN only)
//                level        - difficulty 0..MAX_LEVEL
//                state        - IDLE=0 RUN=1 PAUSE=2 OVER=3
//  Revision    : 1.0 - initial release
// ============================================================================
module game_tick_sched
    import game_pkg::*;
#(
    parameter int PIX_LOG2    = c_DEF_PIX_LOG2,
    parameter int SEG_LOG2    = c_DEF_SEG_LOG2,
    parameter int DINO_LOG2   = c_DEF_DINO_LOG2,
    parameter int CACTUS_LOG2 = c_DEF_CACTUS_LOG2,
    parameter int BLINK_LOG2  = c_DEF_BLINK_LOG2,
    parameter int OBST_LOG2   = c_DEF_OBST_LOG2,
    parameter int LVL_STEP    = c_DEF_LVL_STEP,
    parameter int MAX_LEVEL   = c_DEF_MAX_LEVEL
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 start,
    input  logic                 pause_req,
    input  logic                 collide,
    output logic                 pix_en,
    output logic                 seg_en,
    output logic                 blink_tick,
    output logic                 dino_tick,
    output logic                 cactus_tick,
    output logic                 obst_tick,
    output logic [c_LEVEL_W-1:0] level,
    output logic [1:0]           state
);

    localparam int c_STEP_W = (LVL_STEP > 1) ? $clog2(LVL_STEP) : 1;

    localparam logic [1:0] c_S_IDLE  = ST_IDLE;
    localparam logic [1:0] c_S_RUN   = ST_RUN;
    localparam logic [1:0] c_S_PAUSE = ST_PAUSE;
    localparam logic [1:0] c_S_OVER  = ST_OVER;

    localparam logic [c_STEP_W-1:0]  c_STEP_LAST = c_STEP_W'(LVL_STEP - 1);
    localparam logic [c_LEVEL_W-1:0] c_LVL_MAX   = c_LEVEL_W'(MAX_LEVEL);

    logic [c_PRESC_W-1:0] r_q;
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 w_clear;
    logic [c_LEVEL_W-1:0] r_level;
    logic [c_STEP_W-1:0]  r_step;
    logic                 w_run;
    logic                 w_dino_raw;
    logic [c_EXP_W-1:0]   w_cactus_exp;

    // ------------------------------------------------------------------
    // Free-running prescaler, independent of game state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_q <= '0;
        end else begin
            r_q <= r_q + c_PRESC_W'(1);
        end
    end

    // Gating and step counting both look at the state before the edge, so a
    // raw compare landing on the cycle that enters RUN is not counted.
    assign w_run      = (r_state == c_S_RUN);
    assign w_dino_raw = &r_q[DINO_LOG2-1:0];

    // Level feeds the cactus exponent straight from its register: a new
    // level applies from the following cycle without realigning the period.
    assign w_cactus_exp = c_EXP_W'(CACTUS_LOG2) - c_EXP_W'(r_level);

    // ------------------------------------------------------------------
    // Game state machine
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_state_nxt = c_S_RUN;
                    w_clear     = 1'b1;
                end
            end
            c_S_RUN: begin
                // A hit outranks a simultaneous pause request.
                if (collide) begin
                    w_state_nxt = c_S_OVER;
                end else if (pause_req) begin
                    w_state_nxt = c_S_PAUSE;
                end
            end
            c_S_PAUSE: begin
                // Restart outranks resume when both arrive together.
                if (start) begin
                    w_state_nxt = c_S_RUN;
                    w_clear     = 1'b1;
                end else if (pause_req) begin
                    w_state_nxt = c_S_RUN;
                end
            end
            c_S_OVER: begin
                if (start) begin
                    w_state_nxt = c_S_RUN;
                    w_clear     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Step counter and difficulty level. Game (re)starts only happen from
    // non-RUN states, so the clear never competes with a counted tick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_step  <= '0;
            r_level <= '0;
        end else if (w_clear) begin
            r_step  <= '0;
            r_level <= '0;
        end else if (w_run && w_dino_raw) begin
            if (r_step == c_STEP_LAST) begin
                r_step <= '0;
                if (r_level < c_LVL_MAX) begin
                    r_level <= r_level + c_LEVEL_W'(1);
                end
            end else begin
                r_step <= r_step + c_STEP_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Tick generators
    // ------------------------------------------------------------------
    tick_gen u_pix (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_q    (r_q),
        .i_exp  (c_EXP_W'(PIX_LOG2)),
        .i_gate (1'b1),
        .o_tick (pix_en)
    );

    tick_gen u_seg (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_q    (r_q),
        .i_exp  (c_EXP_W'(SEG_LOG2)),
        .i_gate (1'b1),
        .o_tick (seg_en)
    );

    tick_gen u_blink (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_q    (r_q),
        .i_exp  (c_EXP_W'(BLINK_LOG2)),
        .i_gate (1'b1),
        .o_tick (blink_tick)
    );

    tick_gen u_dino (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_q    (r_q),
        .i_exp  (c_EXP_W'(DINO_LOG2)),
        .i_gate (w_run),
        .o_tick (dino_tick)
    );

    tick_gen u_cactus (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_q    (r_q),
        .i_exp  (w_cactus_exp),
        .i_gate (w_run),
        .o_tick (cactus_tick)
    );

    tick_gen u_obst (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_q    (r_q),
        .i_exp  (c_EXP_W'(OBST_LOG2)),
        .i_gate (w_run),
        .o_tick (obst_tick)
    );

    assign level = r_level;
    assign state = r_state;

endmodule : game_tick_sched
`default_nettype wire

// File: tb/tb_game_tick_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_tick_sched
//  Description : Self-checking bench for game_tick_sched with small periods.
//                A cycle-level reference model built from the game rules
//                checks every sampled cycle; a vector table checks state and
//                level at hand-derived points; hand sequences check the first
//                blink tick and the cactus period at every level.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_tick_sched;

    localparam int PIX    = 1;
    localparam int SEG    = 3;
    localparam int DINO   = 4;
    localparam int CACTUS = 4;
    localparam int BLINK  = 5;
    localparam int OBST   = 6;
    localparam int STEP   = 4;
    localparam int MAXL   = 3;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       start = 1'b0;
    logic       pause_req = 1'b0;
    logic       collide = 1'b0;
    logic       pix_en, seg_en, blink_tick, dino_tick, cactus_tick, obst_tick;
    logic [1:0] level, state;

    game_tick_sched #(
        .PIX_LOG2    (PIX),
        .SEG_LOG2    (SEG),
        .DINO_LOG2   (DINO),
        .CACTUS_LOG2 (CACTUS),
        .BLINK_LOG2  (BLINK),
        .OBST_LOG2   (OBST),
        .LVL_STEP    (STEP),
        .MAX_LEVEL   (MAXL)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .pause_req   (pause_req),
        .collide     (collide),
        .pix_en      (pix_en),
        .seg_en      (seg_en),
        .blink_tick  (blink_tick),
        .dino_tick   (dino_tick),
        .cactus_tick (cactus_tick),
        .obst_tick   (obst_tick),
        .level       (level),
        .state       (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: cycle number since release, game mode, level, step.
    longint m_n;
    int     m_state, m_level, m_step;
    bit     e_pix, e_seg, e_blink, e_dino, e_cactus, e_obst;

    // Cactus period monitor
    bit mon_en = 0;
    int t_now = 0;
    int prev_lvl = 0;
    int last_t = -1;
    int last_pl = 0;
    bit lvl_changed = 0;
    bit seen_period [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Tick for exponent k fires on the edge that completes a multiple of 2**k cycles.
    function automatic bit raw(input int k);
        return ((m_n + 1) % (longint'(1) << k)) == 0;
    endfunction

    task automatic model_edge(input logic s, input logic p, input logic c, input logic rn);
        bit run;
        if (!rn) begin
            m_n = 0; m_state = 0; m_level = 0; m_step = 0;
            e_pix = 0; e_seg = 0; e_blink = 0; e_dino = 0; e_cactus = 0; e_obst = 0;
            return;
        end
        run      = (m_state == 1);
        e_pix    = raw(PIX);
        e_seg    = raw(SEG);
        e_blink  = raw(BLINK);
        e_dino   = run && raw(DINO);
        e_cactus = run && raw(CACTUS - m_level);
        e_obst   = run && raw(OBST);
        if (e_dino) begin
            if (m_step == STEP - 1) begin
                m_step = 0;
                if (m_level < MAXL) m_level++;
            end else begin
                m_step++;
            end
        end
        case (m_state)
            0: if (s) begin m_state = 1; m_level = 0; m_step = 0; end
            1: if (c) m_state = 3; else if (p) m_state = 2;
            2: if (s) begin m_state = 1; m_level = 0; m_step = 0; end
               else if (p) m_state = 1;
            default: if (s) begin m_state = 1; m_level = 0; m_step = 0; end
        endcase
        m_n = (m_n + 1) % (longint'(1) << 31);
    endtask

    task automatic cyc(input logic s, input logic p, input logic c, input logic rn);
        int pl;
        start = s; pause_req = p; collide = c; clr_n = rn;
        @(posedge clk);
        model_edge(s, p, c, rn);
        #1;
        check("cycle", {22'd0, pix_en, seg_en, blink_tick, dino_tick, cactus_tick, obst_tick, level, state},
              {22'd0, e_pix, e_seg, e_blink, e_dino, e_cactus, e_obst, 2'(m_level), 2'(m_state)});
        t_now++;
        pl = prev_lvl;
        if (mon_en) begin
            if (pl != last_pl) lvl_changed = 1;
            if (cactus_tick) begin
                if (last_t >= 0 && !lvl_changed && pl == last_pl) begin
                    check("cactus_period", t_now - last_t, 16 >> pl);
                    seen_period[pl] = 1;
                end
                last_t = t_now;
                last_pl = pl;
                lvl_changed = 0;
            end
        end
        prev_lvl = int'(level);
    endtask

    typedef struct {
        logic       rn;
        logic       s;
        logic       p;
        logic       c;
        int         hold;
        logic [1:0] st;
        logic [1:0] lv;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int first_blink;
        int pix_cnt;

        // Table: apply one input cycle, then `hold` idle cycles, then check.
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0,   0, 2'd0, 2'd0}; // reset
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0,  63, 2'd1, 2'd1}; // start, 4 dino ticks
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0,  20, 2'd2, 2'd1}; // pause
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1,   9, 2'd1, 2'd1}; // resume, collide ignored
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0,  95, 2'd1, 2'd2}; // start ignored, 6 ticks
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1,  30, 2'd3, 2'd2}; // collide beats pause
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0,   0, 2'd1, 2'd0}; // restart from OVER
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 200, 2'd1, 2'd3}; // 13 ticks -> level 3
        tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 100, 2'd1, 2'd3}; // saturated
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0,   0, 2'd0, 2'd0}; // reset mid-game

        // Reset and idle free-run
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("reset", {22'd0, pix_en, seg_en, blink_tick, dino_tick, cactus_tick, obst_tick, level, state}, 32'd0);
        first_blink = -1;
        pix_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(0, 0, 0, 1);
            if (blink_tick && first_blink < 0) first_blink = i;
            if (pix_en) pix_cnt++;
        end
        check("blink_first", first_blink, 32);
        check("pix_count", pix_cnt, 20);

        // Vector table
        for (int r = 0; r < 10; r++) begin
            cyc(tbl[r].s, tbl[r].p, tbl[r].c, tbl[r].rn);
            for (int h = 0; h < tbl[r].hold; h++) cyc(0, 0, 0, 1);
            check($sformatf("table%0d_state", r), state, tbl[r].st);
            check($sformatf("table%0d_level", r), level, tbl[r].lv);
        end

        // Cactus period across all levels
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 1);
        prev_lvl = 0; last_pl = 0; last_t = -1; lvl_changed = 0;
        mon_en = 1;
        for (int i = 0; i < 300; i++) cyc(0, 0, 0, 1);
        mon_en = 0;
        for (int l = 0; l < 4; l++) check($sformatf("cactus_seen_l%0d", l), seen_period[l], 1);

        // Pause freezes the step counter; resume continues from it.
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 1);                               // edge 1: RUN
        for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1);  // ticks at 16,32 -> step 2
        cyc(0, 1, 0, 1);                               // edge 42: PAUSE
        for (int i = 0; i < 50; i++) cyc(0, 0, 0, 1);  // edges 43..92 frozen
        check("pause_level", level, 0);
        cyc(0, 1, 0, 1);                               // edge 93: RUN
        for (int i = 0; i < 19; i++) cyc(0, 0, 0, 1);  // ticks at 96,112 -> level 1
        check("resume_level", level, 1);
        check("resume_state", state, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(99) < 2), ($urandom_range(99) < 3),
                ($urandom_range(99) < 2), !($urandom_range(999) < 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_game_tick_sched
`default_nettype wire
